multi_quotient_accumulator: RTL
===============================

Name: multi_quotient_accumulator

Overview:
- Generalised sum-of-quotients engine: result = sum over i of (num[i] / den[i]), for i = 0..N_CH-1.
- Runs one shared iterative unsigned divider across the channels, one after another, and accumulates the quotients with a selectable wrap or saturate mode.
- Reports divide-by-zero per channel and accumulator overflow.
- Sits between the co-processor command decoder and its result writeback, using the team-standard STB/BUSY handshakes on both sides.

Parameters:
- WIDTH, 16: bit width of each numerator, denominator, quotient and the result.
- N_CH, 4: number of channels; legal range 1..16.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: rst, synchronous, active-low; clock clk.
- in_num  input  N_CH*WIDTH  numerators; channel i is at [i*WIDTH +: WIDTH].
- in_den  input  N_CH*WIDTH  denominators, packed the same way.
- in_sat_en  input  1  accumulation mode: 1 = saturate, 0 = wrap.
- in_stb  input  1  upstream strobe: operands valid.
- in_busy  output  1  block busy; upstream must hold until this is low.
- out_result  output  WIDTH  accumulated result.
- out_div0  output  N_CH  bit i set when den[i] == 0.
- out_ovf  output  1  accumulator exceeded 2^WIDTH-1 at least once.
- out_stb  output  1  result valid.
- out_module_busy  input  1  downstream busy.

Behaviour:
- Reset (rst==0 at a rising edge): in_busy, out_stb, out_result, out_div0 and out_ovf all go to 0; FSM goes to IDLE; accumulator and channel index clear.
  - Applies from any state. An in-flight transaction is discarded with no output strobe.
- Accept: in IDLE, an edge with in_stb==1 and in_busy==0 does all of the following:
  - registers in_num, in_den and in_sat_en;
  - sets in_busy=1 and clears the accumulator, out_div0 and out_ovf;
  - sets ch=0 and moves to LOAD.
  - in_stb while in_busy==1 is ignored; operands are never re-sampled mid-transaction.
- FSM states: IDLE, LOAD, DIV, ACC, DONE.
  - LOAD (1 cycle): start the divider with num[ch] and den[ch]; if den[ch]==0, set out_div0[ch].
  - DIV (exactly WIDTH cycles): restoring division, one quotient bit per cycle, MSB first.
  - ACC (1 cycle): acc_next = acc + q, computed at WIDTH+1 bits.
    - If the carry bit is set: out_ovf <= 1; acc <= all-ones when sat_en, else the low WIDTH bits.
    - If ch == N_CH-1: set out_result <= acc_next (post-mode), out_stb <= 1, go to DONE. Otherwise ch++ and go to LOAD.
  - DONE: out_result, out_div0 and out_ovf are held stable. On an edge with out_stb==1 and out_module_busy==0: out_stb <= 0, in_busy <= 0, go to IDLE.
- Latency: out_stb rises exactly N_CH*(WIDTH+2) cycles after the accept edge. This is constant and does not depend on operand values, including zero divisors.
- Divide by zero: the restoring algorithm with divisor 0 naturally yields q = 2^WIDTH-1. No special datapath; only the flag is set.
- Once saturated, the accumulator stays at all-ones for the rest of the transaction; out_ovf is sticky until the next accept.
- Outputs remain valid after the DONE handshake until the next accept (out_stb is low during that time).
- The earliest new accept is the edge after the DONE handshake edge.

Decomposition:
- Package mqa_pkg holds:
  - the FSM state enum (IDLE, LOAD, DIV, ACC, DONE);
  - localparam CH_W = max(1, $clog2(N_CH));
  - localparam CNT_W = $clog2(WIDTH+1).
- One sub-module, mqa_div_unit: parametrised WIDTH, iterative restoring unsigned divider with ports start, dividend, divisor, done and quotient. It takes WIDTH cycles after start and has the same synchronous active-low reset.
- The top level contains the FSM, operand registers, channel mux and accumulator.

Test Plan:
1. WIDTH=16, N_CH=4, wrap mode; num=(100,50,9,7), den=(10,5,3,7) -> out_result=24, out_div0=0, out_ovf=0, out_stb high 72 cycles after accept.
2. num=(0,0,5,1), den=(1,1,0,1):
   - wrap mode -> out_result=0x0000, out_div0=4'b0100, out_ovf=1;
   - repeat with in_sat_en=1 -> out_result=0xFFFF, out_ovf=1.
3. Hold out_module_busy=1 for 10 cycles after out_stb rises -> out_stb, out_result and in_busy stay constant. Release -> out_stb=0 and in_busy=0 on the next edge; a new in_stb is accepted on the following edge.
4. Assert rst=0 for one edge at cycle 30 of a transaction -> all outputs 0 and no out_stb. A subsequent transaction with the test 1 operands returns 24 at latency 72.
5. Pulse in_stb with different operands at cycle 10 of a busy transaction -> ignored; the result still matches the first operands.
6. WIDTH=8, N_CH=1; num=200, den=7 -> out_result=28, out_stb at latency 10.

Source files
------------

// File: rtl/mqa_pkg.sv
// Shared types and width helpers for the multi-quotient accumulator.
// The default localparams match WIDTH=16, N_CH=4; use the helpers for other sizes.
package mqa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_ACC,
        ST_DONE
    } mqa_state_e;

    function automatic int mqa_ch_w(input int n_ch);
        return (n_ch <= 1) ? 1 : $clog2(n_ch);
    endfunction

    function automatic int mqa_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CH_W  = mqa_ch_w(4);
    localparam int CNT_W = mqa_cnt_w(16);

endpackage

// File: rtl/mqa_div_unit.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// done_o marks the final iteration; quotient_o is valid from the following cycle.
module mqa_div_unit
    import mqa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o
);

    localparam int CW = mqa_cnt_w(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_sh;
    logic             q_bit;

    // Dividend register doubles as the quotient shift register.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        q_bit  = (rem_sh >= {1'b0, dsr_q});
        if (start_i) begin
            cnt_d = CW'(WIDTH);
            rem_d = '0;
            dvd_d = dividend_i;
            dsr_d = divisor_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            rem_d = q_bit ? WIDTH'(rem_sh - {1'b0, dsr_q}) : WIDTH'(rem_sh);
            dvd_d = WIDTH'({dvd_q, q_bit});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dsr_q <= dsr_d;
        end
    end

    assign done_o     = (cnt_q == CW'(1));
    assign quotient_o = dvd_q;

endmodule

// File: rtl/multi_quotient_accumulator.sv
// Sum of num[i]/den[i] over all channels using one shared divider, with wrap or
// saturating accumulation, per-channel divide-by-zero flags and sticky overflow.
//
// state | meaning
// IDLE  | waiting for an upstream strobe
// LOAD  | start divider on channel ch, flag a zero divisor
// DIV   | divider iterating (WIDTH cycles)
// ACC   | add quotient into accumulator, advance or finish
// DONE  | result presented until downstream takes it
module multi_quotient_accumulator
    import mqa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_num,
    input  logic [N_CH*WIDTH-1:0] in_den,
    input  logic                  in_sat_en,
    input  logic                  in_stb,
    output logic                  in_busy,
    output logic [WIDTH-1:0]      out_result,
    output logic [N_CH-1:0]       out_div0,
    output logic                  out_ovf,
    output logic                  out_stb,
    input  logic                  out_module_busy
);

    localparam int CHB = mqa_ch_w(N_CH);

    mqa_state_e            state_q, state_d;
    logic [N_CH*WIDTH-1:0] num_q, num_d, den_q, den_d;
    logic                  sat_q, sat_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [CHB-1:0]        ch_q, ch_d;
    logic                  busy_q, busy_d;
    logic                  stb_q, stb_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic [N_CH-1:0]       div0_q, div0_d;
    logic                  ovf_q, ovf_d;

    logic [WIDTH-1:0] cur_num, cur_den, quot;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_post;
    logic             div_start, div_done;

    assign cur_num   = num_q[ch_q*WIDTH +: WIDTH];
    assign cur_den   = den_q[ch_q*WIDTH +: WIDTH];
    assign div_start = (state_q == ST_LOAD);
    assign sum       = {1'b0, acc_q} + {1'b0, quot};
    assign acc_post  = (sum[WIDTH] && sat_q) ? '1 : sum[WIDTH-1:0];

    mqa_div_unit #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (cur_num),
        .divisor_i  (cur_den),
        .done_o     (div_done),
        .quotient_o (quot)
    );

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        den_d    = den_q;
        sat_d    = sat_q;
        acc_d    = acc_q;
        ch_d     = ch_q;
        busy_d   = busy_q;
        stb_d    = stb_q;
        result_d = result_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_stb && !busy_q) begin
                    num_d   = in_num;
                    den_d   = in_den;
                    sat_d   = in_sat_en;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    div0_d  = '0;
                    ovf_d   = 1'b0;
                    ch_d    = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cur_den == '0) div0_d = div0_q | (N_CH'(1) << ch_q);
                state_d = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) state_d = ST_ACC;
            end
            ST_ACC: begin
                acc_d = acc_post;
                if (sum[WIDTH]) ovf_d = 1'b1;
                if (ch_q == CHB'(N_CH - 1)) begin
                    result_d = acc_post;
                    stb_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    ch_d    = ch_q + CHB'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (stb_q && !out_module_busy) begin
                    stb_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            num_q    <= '0;
            den_q    <= '0;
            sat_q    <= 1'b0;
            acc_q    <= '0;
            ch_q     <= '0;
            busy_q   <= 1'b0;
            stb_q    <= 1'b0;
            result_q <= '0;
            div0_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            den_q    <= den_d;
            sat_q    <= sat_d;
            acc_q    <= acc_d;
            ch_q     <= ch_d;
            busy_q   <= busy_d;
            stb_q    <= stb_d;
            result_q <= result_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_busy    = busy_q;
    assign out_stb    = stb_q;
    assign out_result = result_q;
    assign out_div0   = div0_q;
    assign out_ovf    = ovf_q;

endmodule
